// File: rtl/common_types_pkg.sv
// Shared core types: datapath word width and the RV32M multiply opcode encoding.
package common_types_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_op_t;

endpackage

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add RV32M multiplier for EXECUTE; result held in DONE until ack.
// Define MULT_EARLY_TERM_EN to leave BUSY as soon as the remaining multiplier bits are all zero.
module mult_unit
  import common_types_pkg::*;
#(
  parameter int WORD_W = common_types_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mult,
  input  logic [1:0]        mult_op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ack,
  input  logic              flush,
  output logic              mult_ready,
  output logic [WORD_W-1:0] result
);

  localparam int CNT_W = $clog2(WORD_W) + 1;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  mult_state_t           state_q, state_d;
  logic [2*WORD_W-1:0]   mcand_q, mcand_d;
  logic [2*WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  neg_q, neg_d;
  mult_op_t              op_q, op_d;
  logic [WORD_W-1:0]     result_q, result_d;

  mult_op_t              op_c;
  logic                  a_sgn, b_sgn, last_c;
  logic [WORD_W-1:0]     abs_a, abs_b, mplier_nxt;
  logic [2*WORD_W-1:0]   add_c, prod_c;
  logic [CNT_W-1:0]      cnt_nxt;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;

    // Magnitudes: 2^(W-1) survives as an unsigned W-bit value.
    op_c  = mult_op_t'(mult_op);
    a_sgn = ((op_c == MULH) || (op_c == MULHSU)) && a[WORD_W-1];
    b_sgn = (op_c == MULH) && b[WORD_W-1];
    abs_a = a_sgn ? -a : a;
    abs_b = b_sgn ? -b : b;

    add_c      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_nxt = mplier_q >> 1;
    cnt_nxt    = count_q + CNT_W'(1);
    last_c     = (cnt_nxt == CNT_W'(WORD_W)) || (EARLY_TERM && (mplier_nxt == '0));
    prod_c     = neg_q ? -add_c : add_c;

    case (state_q)
      IDLE: begin
        if (mult) begin
          mcand_d  = {{WORD_W{1'b0}}, abs_a};
          mplier_d = abs_b;
          neg_d    = a_sgn ^ b_sgn;
          op_d     = op_c;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = add_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nxt;
        count_d  = cnt_nxt;
        if (last_c) begin
          state_d  = DONE;
          result_d = (op_q == MUL) ? prod_c[WORD_W-1:0] : prod_c[2*WORD_W-1:WORD_W];
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Squash wins over everything, including a result landing this cycle.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      op_q     <= MUL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign mult_ready = (state_q == DONE);
  assign result     = result_q;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: randomized ops against a 64-bit arithmetic reference model.
module tb_mult_unit;
  import common_types_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, mult = 1'b0, ack = 1'b0, flush = 1'b0;
  logic [1:0]   mult_op = 2'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         mult_ready;
  logic [W-1:0] result;

  mult_unit dut (
    .clk(clk), .rst(rst), .mult(mult), .mult_op(mult_op), .a(a), .b(b),
    .ack(ack), .flush(flush), .mult_ready(mult_ready), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           issue;
    int           lat;
  } exp_t;

  exp_t         q[$];
  int           checks = 0, fails = 0;
  logic [W-1:0] last_res = '0;

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (op)
      2'd1:    p = sx * sy;
      2'd2:    p = sx * uy;
      default: p = ux * uy;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] y);
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] mag;
    int k;
    mag = (op == 2'd1 && y[31]) ? (32'd0 - y) : y;
    k = 1;
    for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
    return k + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a new result is presented.
  logic         rdy_prev = 1'b0;
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (mult_ready && !rdy_prev) begin
      if (q.size() == 0) chk(1'b0, "unexpected_ready", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk(result == e.res, "result", result, e.res);
        chk((cyc - e.issue) == e.lat, "latency", cyc - e.issue, e.lat);
        last_res = e.res;
      end
    end else if (mult_ready) begin
      chk(result == held, "hold_stable", result, held);
    end
    rdy_prev = mult_ready;
    held     = result;
  end

  // Entered and left at a negedge with the DUT idle in the current cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, input bit end_flush);
    exp_t e;
    int   n;
    mult = 1'b1; mult_op = op; a = x; b = y; ack = 1'b0; flush = 1'b0;
    e.res = model(op, x, y); e.issue = cyc; e.lat = model_lat(op, y);
    q.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (mult_ready) break;
      n++;
      if (n > 80) break;
      ack  = ($urandom_range(0, 3) == 0);
      mult = ($urandom_range(0, 3) != 0);
    end
    if (!mult_ready) begin
      chk(1'b0, "timeout", n, e.lat);
      rst = 1'b1; ack = 1'b0; mult = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      last_res = '0;
      return;
    end
    ack = 1'b0; mult = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      chk(mult_ready, "hold_ready", mult_ready, 1);
    end
    if (end_flush) flush = 1'b1;
    else ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; flush = 1'b0; mult = 1'b0;
    if (end_flush) begin
      chk(!mult_ready, "flush_done_ready", mult_ready, 0);
      chk(result == last_res, "flush_done_result", result, last_res);
    end else begin
      chk(!mult_ready, "ack_release", mult_ready, 0);
    end
  endtask

  task automatic flush_busy(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                            input int at);
    mult = 1'b1; mult_op = op; a = x; b = y;
    repeat (at) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mult = 1'b0;
    chk(!mult_ready, "flush_busy_ready", mult_ready, 0);
    chk(result == last_res, "flush_busy_result", result, last_res);
  endtask

  task automatic reset_mid(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    mult = 1'b1; mult_op = op; a = x; b = y;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mult = 1'b0;
    chk(!mult_ready, "rst_mid_ready", mult_ready, 0);
    chk(result == '0, "rst_mid_result", result, 0);
    last_res = '0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk(!mult_ready, "reset_ready", mult_ready, 0);
    chk(result == '0, "reset_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1'b0);
    flush_busy(2'd0, 32'd123, 32'd456, 10);
    run_op(2'd0, 32'd5, 32'd3, 0, 1'b0);
    run_op(2'd0, 32'd5, 32'd0, 0, 1'b0);
    run_op(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b1);
    reset_mid(2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    run_op(2'd2, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk(q.size() == 0, "queue_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
